// File: rtl/fp_multiplier_pipe.sv
// fp_multiplier_pipe: 3-stage RNE float multiplier (clk, rst, in_valid/in_ready/a/b/in_tag in, out_valid/out_ready/result/out_tag/flags out)
module fp_multiplier_pipe #(
  parameter int EXP_LEN = 5,
  parameter int MANT_LEN = 10,
  parameter int FLOAT_LEN = 1 + EXP_LEN + MANT_LEN,
  parameter int TAG_W = 4,
  parameter bit FTZ = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLOAT_LEN-1:0] a,
  input  logic [FLOAT_LEN-1:0] b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FLOAT_LEN-1:0] result,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           flags
);
  localparam int E = EXP_LEN;
  localparam int M = MANT_LEN;
  localparam int XW = EXP_LEN + 2;
  localparam int PW = 2 * MANT_LEN + 2;
  localparam logic signed [XW-1:0] BIAS = XW'((1 << (E - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << E) - 1);
  localparam logic [FLOAT_LEN-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic [M:0] sig;
    logic signed [XW-1:0] exp;
  } op_t;
  function automatic logic [XW-1:0] lzc(input logic [M:0] x);
    logic [XW-1:0] n;
    n = '0;
    for (int i = 0; i <= M; i++) if (x[i]) n = XW'(M - i);
    return n;
  endfunction
  function automatic op_t unpack(input logic [FLOAT_LEN-1:0] x);
    op_t o;
    logic [E-1:0] ef;
    logic [M:0] s;
    logic [XW-1:0] lz;
    ef = x[FLOAT_LEN-2:M];
    s = {|ef, x[M-1:0]};
    lz = lzc(s);
    o.zero = ef == '0 && (FTZ || x[M-1:0] == '0);
    o.inf = &ef && x[M-1:0] == '0;
    o.nan = &ef && x[M-1:0] != '0;
    o.sig = s << lz;
    o.exp = $signed(XW'(ef == '0 ? E'(1) : ef)) - $signed(lz);
    return o;
  endfunction
  logic advance;
  op_t ua, ub;
  logic sign0, nan0, inv0, spec0;
  logic [FLOAT_LEN-1:0] spec_res0;
  assign advance = out_ready || !out_valid;
  assign in_ready = advance;
  assign ua = unpack(a);
  assign ub = unpack(b);
  assign sign0 = a[FLOAT_LEN-1] ^ b[FLOAT_LEN-1];
  assign nan0 = ua.nan || ub.nan;
  assign inv0 = !nan0 && ((ua.inf && ub.zero) || (ua.zero && ub.inf));
  assign spec0 = nan0 || ua.inf || ub.inf || ua.zero || ub.zero;
  assign spec_res0 = nan0 || inv0 ? QNAN :
                     ua.inf || ub.inf ? {sign0, {E{1'b1}}, {M{1'b0}}} :
                     {sign0, {(FLOAT_LEN-1){1'b0}}};
  logic v1, v2;
  logic s1_sign, s1_spec, s1_inv, s2_sign, s2_spec, s2_inv;
  logic signed [XW-1:0] s1_exp, s2_exp;
  logic [M:0] s1_sa, s1_sb;
  logic [PW-1:0] s2_prod;
  logic [FLOAT_LEN-1:0] s1_spec_res, s2_spec_res;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [PW-1:0] n3, shf3, lost3;
  logic signed [XW-1:0] ev3, eo3;
  logic tiny3, g3, r3, st3, up3, inx3, ovf3;
  logic [M:0] mant3;
  logic [M+1:0] mr3;
  logic [M-1:0] field3;
  logic [FLOAT_LEN-1:0] res3;
  logic [3:0] fl3;
  int sh;
  // Tiny results are shifted right into subnormal position; bits shifted out
  // of the word entirely still feed sticky. A rounding carry out of a
  // subnormal lands in the hidden bit, which doubles as the exponent field.
  always_comb begin
    n3 = s2_prod[PW-1] ? s2_prod : s2_prod << 1;
    ev3 = s2_exp + XW'(s2_prod[PW-1]);
    tiny3 = ev3 < 1;
    sh = tiny3 ? 1 - int'(ev3) : 0;
    sh = sh > PW ? PW : sh;
    shf3 = n3 >> sh;
    lost3 = n3 << (PW - sh);
    mant3 = shf3[PW-1:M+1];
    g3 = shf3[M];
    r3 = shf3[M-1];
    st3 = (|lost3) || (|shf3[M-2:0]);
    up3 = g3 && (r3 || st3 || mant3[0]);
    mr3 = {1'b0, mant3} + (M+2)'(up3);
    inx3 = g3 || r3 || st3;
    eo3 = tiny3 ? XW'(mr3[M]) : ev3 + XW'(mr3[M+1]);
    ovf3 = !tiny3 && eo3 >= EMAX;
    field3 = mr3[M+1] ? mr3[M:1] : mr3[M-1:0];
    res3 = s2_spec ? s2_spec_res :
           ovf3 ? {s2_sign, {E{1'b1}}, {M{1'b0}}} :
           FTZ && tiny3 ? {s2_sign, {(FLOAT_LEN-1){1'b0}}} :
           {s2_sign, eo3[E-1:0], field3};
    fl3 = s2_spec ? {s2_inv, 3'b000} :
          ovf3 ? 4'b0101 :
          FTZ && tiny3 ? 4'b0011 :
          {2'b00, tiny3 && inx3, inx3};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      result <= '0;
      out_tag <= '0;
      flags <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      v2 <= v1;
      out_valid <= v2;
      if (v2) begin
        result <= res3;
        out_tag <= s2_tag;
        flags <= fl3;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign <= sign0;
      s1_spec <= spec0;
      s1_inv <= inv0;
      s1_spec_res <= spec_res0;
      s1_exp <= ua.exp + ub.exp - BIAS;
      s1_sa <= ua.sig;
      s1_sb <= ub.sig;
      s1_tag <= in_tag;
      s2_sign <= s1_sign;
      s2_spec <= s1_spec;
      s2_inv <= s1_inv;
      s2_spec_res <= s1_spec_res;
      s2_exp <= s1_exp;
      s2_prod <= PW'(s1_sa) * PW'(s1_sb);
      s2_tag <= s1_tag;
    end
  end
endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// tb_fp_multiplier_pipe: directed checks of fp16, fp16-FTZ and fp32 instances of fp_multiplier_pipe
module tb_fp_multiplier_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic [3:0] in_tag, out_tag, flags;
  logic z_valid, z_in_ready, z_out_valid;
  logic [15:0] za, zb, z_result;
  logic [3:0] z_tag, z_flags;
  logic w_valid, w_in_ready, w_out_valid;
  logic [31:0] wa, wb, w_result;
  logic [3:0] w_tag, w_flags;
  int n_vec = 0;
  int n_err = 0;
  fp_multiplier_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_tag(out_tag), .flags(flags)
  );
  fp_multiplier_pipe #(.FTZ(1'b1)) dut_ftz (
    .clk(clk), .rst(rst), .in_valid(z_valid), .in_ready(z_in_ready), .a(za), .b(zb),
    .in_tag(4'd0), .out_valid(z_out_valid), .out_ready(1'b1), .result(z_result),
    .out_tag(z_tag), .flags(z_flags)
  );
  fp_multiplier_pipe #(.EXP_LEN(8), .MANT_LEN(23)) dut_32 (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_in_ready), .a(wa), .b(wb),
    .in_tag(4'd0), .out_valid(w_out_valid), .out_ready(1'b1), .result(w_result),
    .out_tag(w_tag), .flags(w_flags)
  );
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic op16(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input logic [3:0] t, input logic [15:0] er, input logic [3:0] ef);
    a = x;
    b = y;
    in_tag = t;
    in_valid = 1'b1;
    cyc;
    in_valid = 1'b0;
    cyc;
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    cyc;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, 32'(result), 32'(er));
    chk({tag, "_flags"}, 32'(flags), 32'(ef));
    chk({tag, "_tag"}, 32'(out_tag), 32'(t));
  endtask
  task automatic opz(input string tag, input logic [15:0] x, input logic [15:0] y,
                     input logic [15:0] er, input logic [3:0] ef);
    za = x;
    zb = y;
    z_valid = 1'b1;
    cyc;
    z_valid = 1'b0;
    cyc;
    cyc;
    chk({tag, "_valid"}, 32'(z_out_valid), 32'd1);
    chk({tag, "_res"}, 32'(z_result), 32'(er));
    chk({tag, "_flags"}, 32'(z_flags), 32'(ef));
  endtask
  task automatic opw(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] er, input logic [3:0] ef);
    wa = x;
    wb = y;
    w_valid = 1'b1;
    cyc;
    w_valid = 1'b0;
    cyc;
    cyc;
    chk({tag, "_valid"}, 32'(w_out_valid), 32'd1);
    chk({tag, "_res"}, w_result, er);
    chk({tag, "_flags"}, 32'(w_flags), 32'(ef));
  endtask
  initial begin
    int sent, got;
    logic saw_stall, held_v;
    logic [15:0] held;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    in_tag = '0;
    z_valid = 1'b0;
    za = '0;
    zb = '0;
    w_valid = 1'b0;
    wa = '0;
    wb = '0;
    cyc;
    cyc;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    rst = 1'b0;
    cyc;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    op16("mul_1p5x2", 16'h3E00, 16'h4000, 4'd5, 16'h4200, 4'b0000);
    op16("overflow", 16'h7BFF, 16'h4000, 4'd1, 16'h7C00, 4'b0101);
    op16("inf_x_zero", 16'h7C00, 16'h0000, 4'd2, 16'h7E00, 4'b1000);
    op16("neg_inf", 16'hFC00, 16'h3C00, 4'd3, 16'hFC00, 4'b0000);
    op16("nan_in", 16'h7C01, 16'h3C00, 4'd4, 16'h7E00, 4'b0000);
    op16("neg_zero", 16'h8000, 16'h3C00, 4'd6, 16'h8000, 4'b0000);
    op16("sub_exact", 16'h0400, 16'h3800, 4'd7, 16'h0200, 4'b0000);
    op16("sub_tie_even", 16'h0001, 16'h3800, 4'd8, 16'h0000, 4'b0011);
    op16("sub_tie_odd", 16'h0003, 16'h3800, 4'd9, 16'h0002, 4'b0011);
    op16("sub_to_norm", 16'h03FF, 16'h3C01, 4'd10, 16'h0400, 4'b0011);
    op16("rne_down1", 16'h3C01, 16'h3C01, 4'd11, 16'h3C02, 4'b0001);
    op16("rne_down2", 16'h3C03, 16'h3C01, 4'd12, 16'h3C04, 4'b0001);
    op16("neg_exact", 16'h4400, 16'hC200, 4'd13, 16'hCA00, 4'b0000);
    op16("norm_shift", 16'h3E00, 16'h3E00, 4'd14, 16'h4080, 4'b0000);
    opz("ftz_sub_in", 16'h0200, 16'h3C00, 16'h0000, 4'b0000);
    opz("ftz_tiny_out", 16'h0400, 16'h3800, 16'h0000, 4'b0011);
    opw("f32_mul", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    opw("f32_rne", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    opw("f32_ovf", 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101);
    sent = 0;
    got = 0;
    saw_stall = 1'b0;
    held_v = 1'b0;
    held = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      in_valid = sent < 8;
      a = 16'h3C00 + 16'(sent);
      b = 16'h4000;
      in_tag = 4'(sent);
      out_ready = !(c >= 4 && c <= 7);
      #1;
      if (held_v) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_res", 32'(result), 32'(held));
      end
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        chk("bp_tag", 32'(out_tag), 32'(got));
        chk("bp_res", 32'(result), 32'(16'h4000 + 16'(got)));
        chk("bp_flags", 32'(flags), 32'd0);
        got++;
      end
      held_v = out_valid && !out_ready;
      held = result;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 32'(got), 32'd8);
    chk("bp_sent", 32'(sent), 32'd8);
    chk("bp_stall_seen", 32'(saw_stall), 32'd1);
    cyc;
    chk("bp_drained", 32'(out_valid), 32'd0);
    a = 16'h3E00;
    b = 16'h4000;
    in_tag = 4'd9;
    in_valid = 1'b1;
    cyc;
    in_tag = 4'd10;
    cyc;
    in_valid = 1'b0;
    rst = 1'b1;
    cyc;
    chk("rstmid_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc;
      chk("rstmid_flushed", 32'(out_valid), 32'd0);
    end
    op16("post_rst", 16'h3E00, 16'h4000, 4'd11, 16'h4200, 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fp_multiplier_pipe.md
Name: fp_multiplier_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point multiplier. It is the clocked successor to the combinational float16 multiplier in the activation accelerator datapath. It supports configurable exponent and mantissa widths, a valid/ready stream handshake with backpressure, a sideband tag, round-to-nearest-even, subnormals (optionally flushed) and exception flags. It sits between the operand fetch stage and the activation accumulate/lookup stages.

Parameters:
EXP_LEN, 5, exponent field width (bias = 2^(EXP_LEN-1)-1)
MANT_LEN, 10, stored mantissa field width
FLOAT_LEN, 1+EXP_LEN+MANT_LEN, total word width (derived; never overridden)
TAG_W, 4, sideband tag width carried alongside each operation
FTZ, 0, 1 = subnormal inputs are treated as zero and subnormal results flush to signed zero

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands this cycle
a  in  FLOAT_LEN  operand A
b  in  FLOAT_LEN  operand B
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  FLOAT_LEN  product
out_tag  out  TAG_W  tag of this result
flags  out  4  {invalid, overflow, underflow, inexact}, aligned with result

Behaviour:
- Reset (rst=1 at a clk edge): all stage valids clear. out_valid=0, result=0, out_tag=0, flags=0. in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight operations; no result is emitted for them.
- Pipeline: 3 register stages, latency exactly 3 cycles from accept (in_valid&&in_ready) to out_valid, when there is no backpressure. Throughput is 1 per cycle.
- Stage 1: unpack fields; classify each operand as zero/subnormal/normal/inf/NaN. Sign = a.s ^ b.s. Exponent sum uses EXP_LEN+2-bit signed arithmetic. Subnormals get the implicit bit 0 and effective exponent 1, then a leading-zero normalise.
- Stage 2: full (MANT_LEN+1)x(MANT_LEN+1) product, 2*MANT_LEN+2 bits.
- Stage 3: normalise by 0 or 1 bit. If the exponent is below 1, right-shift (underflow path) with sticky collection. Then RNE using guard, round and sticky bits. A mantissa carry-out after rounding increments the exponent.
- Global stall: advance = out_ready || !out_valid. in_ready = advance (combinational). When advance=0, every stage holds its value, and result/out_tag/flags stay stable while out_valid=1.
- Bubbles: a stage with valid=0 passes through; its data contents are don't-care but outputs are gated so that result holds its last value.
- Special cases (override arithmetic):
  - NaN on either input -> quiet NaN {0, all-ones exp, 1 followed by zeros}, invalid=0.
  - inf*0 -> quiet NaN, invalid=1.
  - inf*finite-nonzero -> signed inf.
  - zero*finite -> signed zero, no flags.
- Overflow: rounded exponent >= 2^EXP_LEN-1 -> signed inf, overflow=1, inexact=1.
- Underflow: result is tiny (pre-round exponent < 1) and inexact -> underflow=1. With FTZ=1, any tiny result becomes signed zero with underflow=1, inexact=1.
- Exact subnormal result: no underflow flag.
- inexact = any discarded nonzero bit (guard|round|sticky) on finite results.
- Subnormal-to-normal rounding carry yields the minimum normal with the correct exponent.

Test Plan:
- fp16: a=0x3E00 (1.5), b=0x4000 (2.0), tag=5 -> after exactly 3 cycles result=0x4200, out_tag=5, flags=0000.
- a=0x7BFF, b=0x4000 -> result=0x7C00, flags: overflow=1, inexact=1. a=0x7C00, b=0x0000 -> result=0x7E00, invalid=1. a=0xFC00, b=0x3C00 -> 0xFC00, flags=0.
- Subnormal: a=0x0400, b=0x3800 -> 0x0200, flags=0. a=0x0001, b=0x3800 -> 0x0000, underflow=1, inexact=1 (tie to even). With FTZ=1, a=0x0200, b=0x3C00 -> 0x0000.
- Rounding: a=0x3C01, b=0x3C01 -> 0x3C02, inexact=1. a=0x3C03, b=0x3C01 -> 0x3C04 (1+4*2^-10+3*2^-20 rounds down), inexact=1.
- Backpressure: stream 8 back-to-back ops with tags 0..7 while holding out_ready=0 for cycles 4-7 -> in_ready drops, no op is lost or duplicated, results emerge in tag order, and result stays stable while stalled.
- Reset mid-stream (rst pulse while 2 ops are in flight) -> out_valid=0 the next cycle, neither op is emitted, a new op issued afterwards returns after 3 cycles. Regression: random fp16 vs. shortreal golden, plus one EXP_LEN=8/MANT_LEN=23 instance checked bit-exact.
